// File: rtl/regfile_pkg.sv
// Shared register-file definitions: ID width, the "no register" ID and the ID range check.
package regfile_pkg;

    localparam int unsigned ID_W_DEF = 4;
    localparam logic [ID_W_DEF-1:0] RNONE = '1;

    typedef logic [ID_W_DEF-1:0] reg_id_t;

    // The caller separately excludes the all-ones ID when its ID width differs from ID_W_DEF.
    function automatic logic id_valid(input logic [31:0] id, input int unsigned nregs);
        return (id < nregs) && (id != 32'(RNONE));
    endfunction

endpackage

// File: rtl/regfile_wdec.sv
// One-hot decoder for a register ID.
// The output is all zeros when the ID is the all-ones "no register" ID or when it is out of range.
module regfile_wdec
    import regfile_pkg::*;
#(
    parameter int unsigned ID_W  = ID_W_DEF,
    parameter int unsigned NREGS = 8
) (
    input  logic              en,
    input  logic [ID_W-1:0]   id,
    output logic [NREGS-1:0]  onehot
);

    logic id_ok;

    always_comb begin
        id_ok  = en && (id != '1) && id_valid(32'(id), NREGS);
        onehot = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (id_ok && (32'(id) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write (E, M), two-read (A, B) register file with a per-register pending scoreboard.
// Define REGFILE_BYPASS_EN to make the read data and the pending outputs show the state after the edge.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ID_W   = ID_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ID_W-1:0]         dstE,
    input  logic [DATA_W-1:0]       valE,
    input  logic [ID_W-1:0]         dstM,
    input  logic [DATA_W-1:0]       valM,
    input  logic [ID_W-1:0]         srcA,
    input  logic [ID_W-1:0]         srcB,
    output logic [DATA_W-1:0]       rdA,
    output logic [DATA_W-1:0]       rdB,
    input  logic                    claim_en,
    input  logic [ID_W-1:0]         claim_id,
    output logic                    pendA,
    output logic                    pendB,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] rd_src [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d, pend_src;
    logic [NREGS-1:0]  we_e, we_m, claim_oh;
    logic [DATA_W-1:0] rda_q, rda_d, rdb_q, rdb_d;
    logic              penda_q, penda_d, pendb_q, pendb_d;

    regfile_wdec #(.ID_W(ID_W), .NREGS(NREGS)) u_dec_e (
        .en     (1'b1),
        .id     (dstE),
        .onehot (we_e)
    );

    regfile_wdec #(.ID_W(ID_W), .NREGS(NREGS)) u_dec_m (
        .en     (1'b1),
        .id     (dstM),
        .onehot (we_m)
    );

    regfile_wdec #(.ID_W(ID_W), .NREGS(NREGS)) u_dec_claim (
        .en     (claim_en),
        .id     (claim_id),
        .onehot (claim_oh)
    );

    // M writes back after E, so M wins a collision. A new claim outranks a write that retires an older producer.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we_m[i]) begin
                regs_d[i] = valM;
            end else if (we_e[i]) begin
                regs_d[i] = valE;
            end
        end
        pend_d = (pend_q & ~(we_e | we_m)) | claim_oh;
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_src   = regs_d;
    assign pend_src = pend_d;
`else
    assign rd_src   = regs_q;
    assign pend_src = pend_q;
`endif

    // Reads of an invalid or out-of-range ID match no register, so they return 0.
    always_comb begin
        rda_d   = '0;
        rdb_d   = '0;
        penda_d = 1'b0;
        pendb_d = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(srcA) == i) begin
                rda_d   = rd_src[i];
                penda_d = pend_src[i];
            end
            if (32'(srcB) == i) begin
                rdb_d   = rd_src[i];
                pendb_d = pend_src[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q  <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            penda_q <= 1'b0;
            pendb_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q  <= pend_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            penda_q <= penda_d;
            pendb_q <= pendb_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign rdA   = rda_q;
    assign rdB   = rdb_q;
    assign pendA = penda_q;
    assign pendB = pendb_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default 32x8 instance and a 64x15 instance.
// Expected values come from a behavioural model; REGFILE_BYPASS_EN selects the post-edge view.
module tb_regfile_mp;

    logic         clock = 1'b0;
    logic         reset = 1'b0;

    logic [3:0]   dstE = 4'hF, dstM = 4'hF, srcA = 4'hF, srcB = 4'hF, claim_id = 4'hF;
    logic [31:0]  valE = '0, valM = '0;
    logic         claim_en = 1'b0;
    logic [31:0]  rdA, rdB;
    logic         pendA, pendB;
    logic [255:0] regs_flat;

    logic [3:0]   dstE2 = 4'hF, dstM2 = 4'hF, srcA2 = 4'hF, srcB2 = 4'hF, claim_id2 = 4'hF;
    logic [63:0]  valE2 = '0, valM2 = '0;
    logic         claim_en2 = 1'b0;
    logic [63:0]  rdA2, rdB2;
    logic         pendA2, pendB2;
    logic [959:0] regs_flat2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          kind;
        int          idx;
        logic [63:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_regs [8];
    logic [7:0]  m_pend;

    always #5 clock = ~clock;

    regfile_mp #(.DATA_W(32), .NREGS(8), .ID_W(4)) u_dut (
        .clock(clock), .reset(reset),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB),
        .claim_en(claim_en), .claim_id(claim_id),
        .pendA(pendA), .pendB(pendB), .regs_flat(regs_flat)
    );

    regfile_mp #(.DATA_W(64), .NREGS(15), .ID_W(4)) u_big (
        .clock(clock), .reset(reset),
        .dstE(dstE2), .valE(valE2), .dstM(dstM2), .valM(valM2),
        .srcA(srcA2), .srcB(srcB2), .rdA(rdA2), .rdB(rdB2),
        .claim_en(claim_en2), .claim_id(claim_id2),
        .pendA(pendA2), .pendB(pendB2), .regs_flat(regs_flat2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] actual(input int kind, input int idx);
        case (kind)
            0:       return 64'(rdA);
            1:       return 64'(rdB);
            2:       return 64'(pendA);
            3:       return 64'(pendB);
            default: return 64'(regs_flat[idx*32 +: 32]);
        endcase
    endfunction

    function automatic string kind_name(input int kind, input int idx);
        case (kind)
            0:       return "rdA";
            1:       return "rdB";
            2:       return "pendA";
            3:       return "pendB";
            default: return $sformatf("r%0d", idx);
        endcase
    endfunction

    // Applies one cycle of stimulus, predicts the outcome and compares it after the edge.
    task automatic drive(input int e, input logic [31:0] ve, input int m, input logic [31:0] vm,
                         input int a, input int b, input bit ce, input int cid);
        logic [31:0] nr [8];
        logic [7:0]  np;
        logic [31:0] view [8];
        logic [7:0]  pview;
        dstE = 4'(e); valE = ve; dstM = 4'(m); valM = vm;
        srcA = 4'(a); srcB = 4'(b); claim_en = ce; claim_id = 4'(cid);
        nr = m_regs;
        np = m_pend;
        if (e < 8) begin nr[e] = ve; np[e] = 1'b0; end
        if (m < 8) begin nr[m] = vm; np[m] = 1'b0; end
        if (ce && cid < 8) np[cid] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        view = nr;  pview = np;
`else
        view = m_regs; pview = m_pend;
`endif
        sb.push_back('{0, 0, (a < 8) ? 64'(view[a]) : 64'd0});
        sb.push_back('{1, 0, (b < 8) ? 64'(view[b]) : 64'd0});
        sb.push_back('{2, 0, (a < 8) ? 64'(pview[a]) : 64'd0});
        sb.push_back('{3, 0, (b < 8) ? 64'(pview[b]) : 64'd0});
        for (int i = 0; i < 8; i++) sb.push_back('{4, i, 64'(nr[i])});
        m_regs = nr;
        m_pend = np;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check(kind_name(x.kind, x.idx), actual(x.kind, x.idx), x.exp);
        end
    endtask

    task automatic idle();
        drive(15, 0, 15, 0, 15, 15, 0, 15);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_pend = '0;

        // Reset held with a live write and claim present; nothing may change.
        dstE = 4'd0; valE = 32'hABCDEF98; srcA = 4'd0; srcB = 4'd1;
        claim_en = 1'b1; claim_id = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rdA", 64'(rdA), 64'd0);
        check("rst_rdB", 64'(rdB), 64'd0);
        check("rst_pendA", 64'(pendA), 64'd0);
        check("rst_pendB", 64'(pendB), 64'd0);
        check("rst_flat_lo", regs_flat[127:0], 64'd0);
        check("rst_flat_hi", regs_flat[255:128], 64'd0);
        check("rst_big_r0", regs_flat2[63:0], 64'd0);
        claim_en = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        drive(0, 32'hABCDEF98, 15, 0, 0, 1, 0, 15);

        // Collision: M wins, then independent E and M writes.
        drive(3, 32'h11111111, 3, 32'h22222222, 0, 3, 0, 15);
        drive(4, 32'h11111111, 5, 32'h22222222, 3, 3, 0, 15);
        drive(15, 0, 15, 0, 4, 5, 0, 15);

        // Invalid destinations and an invalid read address.
        drive(15, 32'hDEADBEEF, 8, 32'hCAFEF00D, 15, 4, 0, 15);
        drive(15, 0, 15, 0, 15, 9, 0, 15);

        // Read-during-write on r2.
        drive(2, 32'd5, 15, 0, 15, 15, 0, 15);
        drive(2, 32'd9, 15, 0, 2, 2, 0, 15);
        drive(15, 0, 15, 0, 2, 15, 0, 15);

        // Scoreboard on r6, including the claim-versus-write tie.
        drive(15, 0, 15, 0, 6, 6, 1, 6);
        drive(15, 0, 15, 0, 6, 6, 0, 15);
        drive(15, 0, 6, 32'h66, 6, 6, 0, 15);
        drive(15, 0, 15, 0, 6, 6, 0, 15);
        drive(15, 0, 6, 32'h67, 6, 6, 1, 6);
        drive(15, 0, 15, 0, 6, 6, 1, 9);
        drive(6, 32'h68, 15, 0, 6, 6, 0, 15);
        drive(15, 0, 15, 0, 6, 6, 0, 15);

        for (int n = 0; n < 40; n++) begin
            drive($urandom_range(0, 15), $urandom, $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15));
        end
        idle();

        // Wide instance: r14 lands in the top slice; RNONE writes are dropped.
        dstE2 = 4'd14; valE2 = 64'h0123456789ABCDEF;
        dstM2 = 4'd15; valM2 = 64'hFFFF0000FFFF0000;
        @(posedge clock);
        #1;
        dstE2 = 4'd15; srcA2 = 4'd14; srcB2 = 4'd15;
        check("big_r14", regs_flat2[14*64 +: 64], 64'h0123456789ABCDEF);
        check("big_low", 64'(|regs_flat2[14*64-1:0]), 64'd0);
        @(posedge clock);
        #1;
        check("big_rdA", rdA2, 64'h0123456789ABCDEF);
        check("big_rdB", rdB2, 64'd0);

        // An asynchronous reset in mid-cycle clears the state at once.
        drive(1, 32'h5A5A5A5A, 15, 0, 1, 1, 1, 1);
        drive(15, 0, 15, 0, 1, 1, 0, 15);
        #2 reset = 1'b0;
        #1;
        check("arst_rdA", 64'(rdA), 64'd0);
        check("arst_pendA", 64'(pendA), 64'd0);
        check("arst_flat", 64'(|regs_flat), 64'd0);
        check("arst_big", 64'(|regs_flat2), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
